// File: rtl/slc3_io_pkg.sv
// ---------------------------------------------------------------------------
// slc3_io_pkg
// Shared types and constants for the SLC-3 board-input front end.
//   btn_state_t      : per-button debounce FSM state
//   DEFAULT_DEBOUNCE : default number of stable synchronized cycles before a
//                      button level is accepted
// ---------------------------------------------------------------------------
package slc3_io_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } btn_state_t;

    localparam int DEFAULT_DEBOUNCE = 16;

endpackage : slc3_io_pkg

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One pushbutton: 2-flop synchronizer, debounce FSM and stability counter.
//   Clk    : system clock
//   Reset  : asynchronous, active-high reset
//   raw    : raw button, asynchronous to Clk
//   level  : debounced button level (registered)
//   pulse  : one-cycle strobe on a debounced rising edge (registered)
// ---------------------------------------------------------------------------
module btn_debounce
    import slc3_io_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             q1;
    logic             q2;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer; only q2 is ever looked at downstream.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours; with blocking
            // assignments q2 would collapse onto q1 and the synchronizer
            // would lose a stage.
            q1 <= raw;
            q2 <= q1;
        end
    end

    // The counter is cleared on every state change and only advances while
    // below CNT_MAX, so it can never wrap.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_LOW;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                S_LOW: begin
                    if (q2) begin
                        state <= S_RISE;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                S_RISE: begin
                    if (!q2) begin
                        state <= S_LOW;         // bounce rejected
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                        level <= 1'b1;
                        pulse <= 1'b1;          // coincides with level rising
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!q2) begin
                        state <= S_FALL;
                        cnt   <= CNT_ONE;
                    end
                end
                S_FALL: begin
                    if (q2) begin
                        state <= S_HIGH;        // bounce rejected
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= S_LOW;
                        cnt   <= '0;
                        level <= 1'b0;          // no strobe on release
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= S_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule : btn_debounce

// File: rtl/slc3_input_conditioner.sv
// ---------------------------------------------------------------------------
// slc3_input_conditioner
// Board-input front end for the SLC-3: synchronizes the slide switches and
// synchronizes + debounces the Run and Continue pushbuttons.
//   Clk            : system clock
//   Reset          : asynchronous, active-high reset
//   run_raw        : raw Run button
//   continue_raw   : raw Continue button
//   sw_raw         : raw slide switches [SW_W]
//   run_level      : debounced Run level
//   run_pulse      : one-cycle strobe on debounced Run rising edge
//   continue_level : debounced Continue level
//   continue_pulse : one-cycle strobe on debounced Continue rising edge
//   sw_sync        : switches after a 2-flop synchronizer [SW_W]
// ---------------------------------------------------------------------------
module slc3_input_conditioner
    import slc3_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int SW_W            = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            run_raw,
    input  logic            continue_raw,
    input  logic [SW_W-1:0] sw_raw,
    output logic            run_level,
    output logic            run_pulse,
    output logic            continue_level,
    output logic            continue_pulse,
    output logic [SW_W-1:0] sw_sync
);

    logic [SW_W-1:0] sw_q1;
    logic [SW_W-1:0] sw_q2;

    // Switches are level inputs read by software, so they are synchronized
    // but deliberately not debounced.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sw_q1 <= '0;
            sw_q2 <= '0;
        end else begin
            sw_q1 <= sw_raw;
            sw_q2 <= sw_q1;
        end
    end

    assign sw_sync = sw_q2;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run_db (
        .Clk   (Clk),
        .Reset (Reset),
        .raw   (run_raw),
        .level (run_level),
        .pulse (run_pulse)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_continue_db (
        .Clk   (Clk),
        .Reset (Reset),
        .raw   (continue_raw),
        .level (continue_level),
        .pulse (continue_pulse)
    );

endmodule : slc3_input_conditioner

// File: tb/tb_slc3_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_slc3_input_conditioner
// Self-checking bench for slc3_input_conditioner with DEBOUNCE_CYCLES=4.
// Reference model: each button is a two-stage delay line followed by a rule
// "the level flips once the synchronized input has disagreed with it on
// DEBOUNCE_CYCLES+1 consecutive edges; a flip to 1 also raises the strobe".
// ---------------------------------------------------------------------------
module tb_slc3_input_conditioner;
    import slc3_io_pkg::*;

    localparam int DB   = 4;
    localparam int SW_W = 16;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            run_raw;
    logic            continue_raw;
    logic [SW_W-1:0] sw_raw;
    logic            run_level;
    logic            run_pulse;
    logic            continue_level;
    logic            continue_pulse;
    logic [SW_W-1:0] sw_sync;

    slc3_input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .SW_W            (SW_W)
    ) u_dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .run_raw        (run_raw),
        .continue_raw   (continue_raw),
        .sw_raw         (sw_raw),
        .run_level      (run_level),
        .run_pulse      (run_pulse),
        .continue_level (continue_level),
        .continue_pulse (continue_pulse),
        .sw_sync        (sw_sync)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic s1;
        logic s2;
        logic lvl;
        logic pls;
        int   streak;
    } btn_model_t;

    btn_model_t      m_run;
    btn_model_t      m_cont;
    logic [SW_W-1:0] m_sw1;
    logic [SW_W-1:0] m_sw2;

    function automatic btn_model_t btn_edge(input btn_model_t m, input logic raw);
        btn_model_t n;
        n     = m;
        n.pls = 1'b0;
        if (m.s2 != m.lvl) begin
            n.streak = m.streak + 1;
            if (n.streak == DB + 1) begin
                n.lvl    = ~m.lvl;
                n.pls    = n.lvl;
                n.streak = 0;
            end
        end else begin
            n.streak = 0;
        end
        n.s2 = m.s1;
        n.s1 = raw;
        return n;
    endfunction

    task automatic model_reset();
        m_run  = '{s1: 1'b0, s2: 1'b0, lvl: 1'b0, pls: 1'b0, streak: 0};
        m_cont = '{s1: 1'b0, s2: 1'b0, lvl: 1'b0, pls: 1'b0, streak: 0};
        m_sw1  = '0;
        m_sw2  = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".run_level"},      32'(run_level),      32'(m_run.lvl));
        check({tag, ".run_pulse"},      32'(run_pulse),      32'(m_run.pls));
        check({tag, ".continue_level"}, 32'(continue_level), 32'(m_cont.lvl));
        check({tag, ".continue_pulse"}, 32'(continue_pulse), 32'(m_cont.pls));
        check({tag, ".sw_sync"},        32'(sw_sync),        32'(m_sw2));
    endtask

    // One rising edge: advance the model with the inputs present at the
    // edge, then sample the DUT 1 time unit later.
    task automatic step(input string tag);
        @(posedge Clk);
        m_run  = btn_edge(m_run, run_raw);
        m_cont = btn_edge(m_cont, continue_raw);
        m_sw2  = m_sw1;
        m_sw1  = sw_raw;
        #1;
        check_outputs(tag);
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic pulse_reset(input string tag);
        Reset = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        #1;
        Reset = 1'b0;
    endtask

    int n_pulse;
    int pulse_at;
    int p_run;
    int p_cont;

    initial begin
        logic [4:0] bounce;

        Reset        = 1'b0;
        run_raw      = 1'b0;
        continue_raw = 1'b0;
        sw_raw       = '0;
        model_reset();

        // 1. Reset with all inputs low: outputs clear without any edge.
        #2;
        Reset = 1'b1;
        #1;
        check("t1_imm_run_level", 32'(run_level), 32'd0);
        check("t1_imm_sw_sync",   32'(sw_sync),   32'd0);
        check_outputs("t1_imm");
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) step("t1_idle");

        // 2. Run press: level/pulse after edge 6, pulse gone after edge 7.
        run_raw = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step("t2");
            if (e == 5) check("t2_level_e5", 32'(run_level), 32'd0);
            if (e == 6) begin
                check("t2_level_e6", 32'(run_level), 32'd1);
                check("t2_pulse_e6", 32'(run_pulse), 32'd1);
            end
            if (e == 7) check("t2_pulse_e7", 32'(run_pulse), 32'd0);
            check("t2_cont_level", 32'(continue_level), 32'd0);
        end

        // 3. Continue bounces 1,0,1,1,0 then holds 1.
        bounce  = 5'b01101;     // applied LSB first
        n_pulse = 0;
        for (int i = 0; i < 5; i++) begin
            continue_raw = bounce[i];
            step("t3_bounce");
            if (continue_pulse) n_pulse++;
        end
        check("t3_bounce_pulses", 32'(n_pulse), 32'd0);
        continue_raw = 1'b1;
        n_pulse  = 0;
        pulse_at = -1;
        for (int e = 0; e < 12; e++) begin
            step("t3_hold");
            if (continue_pulse) begin
                n_pulse++;
                pulse_at = e;
            end
        end
        check("t3_pulse_count", 32'(n_pulse),  32'd1);
        check("t3_pulse_edge",  32'(pulse_at), 32'd6);

        // 4. Run release: level falls after edge 6, no pulse; re-press pulses once.
        run_raw = 1'b0;
        n_pulse = 0;
        for (int e = 0; e < 9; e++) begin
            step("t4_rel");
            if (run_pulse) n_pulse++;
            if (e == 5) check("t4_level_e5", 32'(run_level), 32'd1);
            if (e == 6) check("t4_level_e6", 32'(run_level), 32'd0);
        end
        check("t4_fall_pulses", 32'(n_pulse), 32'd0);
        run_raw = 1'b1;
        n_pulse = 0;
        for (int e = 0; e < 10; e++) begin
            step("t4_repress");
            if (run_pulse) n_pulse++;
        end
        check("t4_repress_pulses", 32'(n_pulse), 32'd1);

        // 5. Switch synchronizer latency: two edges.
        sw_raw = 16'h0003;
        for (int i = 0; i < 3; i++) step("t5_settle");
        sw_raw = 16'hA5A5;
        step("t5");
        check("t5_sw_after1", 32'(sw_sync), 32'h0003);
        step("t5");
        check("t5_sw_after2", 32'(sw_sync), 32'hA5A5);
        sw_raw = 16'hA5A4;
        step("t5_bit");
        check("t5_bit_after1", 32'(sw_sync), 32'hA5A5);
        step("t5_bit");
        check("t5_bit_after2", 32'(sw_sync), 32'hA5A4);

        // 6. Button held through reset release, then reset mid-count.
        run_raw      = 1'b0;
        continue_raw = 1'b0;
        for (int i = 0; i < 10; i++) step("t6_settle");
        Reset   = 1'b1;
        run_raw = 1'b1;
        #1;
        model_reset();
        check_outputs("t6_reset");
        repeat (3) @(posedge Clk);
        #2;
        Reset   = 1'b0;
        n_pulse = 0;
        for (int e = 0; e < 10; e++) begin
            step("t6_held");
            if (run_pulse) n_pulse++;
            if (e == 6) check("t6_pulse_e6", 32'(run_pulse), 32'd1);
        end
        check("t6_held_pulses", 32'(n_pulse), 32'd1);
        run_raw = 1'b0;
        for (int i = 0; i < 10; i++) step("t6_release");
        run_raw = 1'b1;
        for (int i = 0; i < 5; i++) step("t6_midcount");
        check("t6_state_midcount", 32'(u_dut.u_run_db.state), 32'(S_RISE));
        Reset = 1'b1;
        #1;
        model_reset();
        check_outputs("t6_midreset");
        check("t6_state_reset", 32'(u_dut.u_run_db.state), 32'(S_LOW));
        run_raw = 1'b0;
        #1;
        Reset   = 1'b0;
        n_pulse = 0;
        for (int i = 0; i < 12; i++) begin
            step("t6_after");
            if (run_pulse) n_pulse++;
        end
        check("t6_after_pulses", 32'(n_pulse), 32'd0);

        // 7. Randomized: bursts of bounce-rich and stable button activity,
        //    random switches and occasional asynchronous resets.
        for (int blk = 0; blk < 15; blk++) begin
            p_run  = 1 << $urandom_range(1, 4);
            p_cont = 1 << $urandom_range(1, 4);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, p_run - 1) == 0)  run_raw      = ~run_raw;
                if ($urandom_range(0, p_cont - 1) == 0) continue_raw = ~continue_raw;
                if ($urandom_range(0, 3) == 0)          sw_raw       = SW_W'($urandom);
                step("rnd");
                if ($urandom_range(0, 399) == 0) pulse_reset("rnd_reset");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_slc3_input_conditioner

// File: doc/slc3_input_conditioner.md
Name: slc3_input_conditioner

Overview:
Board-input front end that sits directly upstream of the SLC-3 top level. It takes the raw, asynchronous Run and Continue pushbuttons and the 16 slide switches, and synchronizes them to Clk. The two buttons are also debounced, and each produces a clean level plus a single-cycle rising-edge pulse. Its outputs drive the processor's Run, Continue and SW inputs.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required before a button level is accepted; must be >= 1; set to 500000 for the board build.
SW_W, 16, switch bus width.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, never overridden.

Ports:
Clk  input  1  system clock.
Reset  input  1  asynchronous, active-high reset.
run_raw  input  1  raw Run button, asynchronous to Clk.
continue_raw  input  1  raw Continue button, asynchronous to Clk.
sw_raw  input  SW_W  raw slide switches, asynchronous to Clk.
run_level  output  1  debounced Run level.
run_pulse  output  1  one-cycle strobe on a debounced Run rising edge.
continue_level  output  1  debounced Continue level.
continue_pulse  output  1  one-cycle strobe on a debounced Continue rising edge.
sw_sync  output  SW_W  switches after the 2-flop synchronizer.

Behaviour:
- One clock (Clk). Reset is asynchronous and active-high.
- Reset effect (immediate, independent of Clk):
  - all synchronizer flops, counters and outputs go to 0;
  - both button FSMs go to S_LOW.
- Synchronizer:
  - every input passes through 2 flops (q1, q2).
  - q2 is the only value the debounce logic or sw_sync ever uses.
  - sw_sync = q2 of sw_raw; latency is exactly 2 rising edges; no debounce on switches.
- Per-button FSM, states S_LOW, S_RISE, S_HIGH, S_FALL:
  - S_LOW: if q2=1, go to S_RISE with cnt=1; otherwise stay with cnt=0.
  - S_RISE:
    - q2=0: back to S_LOW, cnt=0 (glitch rejected).
    - q2=1 and cnt==DEBOUNCE_CYCLES: go to S_HIGH, cnt=0, level=1, pulse=1.
    - otherwise: cnt+1.
  - S_HIGH: if q2=0, go to S_FALL with cnt=1.
  - S_FALL:
    - q2=1: back to S_HIGH, cnt=0.
    - q2=0 and cnt==DEBOUNCE_CYCLES: go to S_LOW, cnt=0, level=0. No pulse on a fall.
    - otherwise: cnt+1.
  - level and pulse are registered outputs.
  - pulse is high for exactly one cycle, on the same edge where level rises.
- Press latency: if raw goes high before edge E0 and stays high:
  - q2=1 after edge E1;
  - level and pulse assert after edge E1+DEBOUNCE_CYCLES+1.
- Release latency is the same as press latency.
- Glitches: any bounce that returns within DEBOUNCE_CYCLES synchronized cycles produces no level change and no pulse.
- Counter cannot overflow: it is cleared on every transition and saturates at DEBOUNCE_CYCLES by construction.
- Button held through reset release: it is treated as a new press and produces one pulse after the normal latency.
- Reset mid-debounce: the count is discarded and no pulse is emitted.
- Run and Continue are fully independent. Simultaneous presses give simultaneous pulses.

Decomposition:
- Package slc3_io_pkg holds:
  - typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} btn_state_t;
  - localparam DEFAULT_DEBOUNCE = 16.
- Sub-module btn_debounce contains the synchronizer, FSM and counter for one bit. It is instantiated twice, for Run and Continue.
- Switch synchronization is inline in the top level.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset pulse with all inputs 0 -> every output is 0 immediately, with no Clk edge needed. Outputs stay 0 for 20 cycles after release.
2. run_raw 0->1 before edge 0 and held high -> run_level=1 and run_pulse=1 after edge 6. run_pulse=0 after edge 7. continue_* stays 0 throughout.
3. continue_raw bounces 1,0,1,1,0 then holds 1 -> no pulse during the bounce. Exactly one continue_pulse, 6 edges after the last 0->1 transition.
4. Run held high, then released -> run_level falls 6 edges after the release. No pulse on the fall. A second press gives a second single pulse.
5. sw_raw=16'h0003 changes to 16'hA5A5 -> sw_sync=16'h0003 until edge 1 and 16'hA5A5 after edge 2. Same timing for a single-bit toggle.
6. run_raw high through Reset release, and Reset reasserted mid-count on a second attempt -> first attempt: one pulse 6 edges after release. Reasserted reset: no pulse, and the FSM is back in S_LOW immediately.
